// File: rtl/shift_rx_pkg.sv
// Shared types and constants for the LSB-first serial receiver.
// Optional parity support is enabled with SHIFT_RX_PARITY_EN.
package shift_rx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } state_t;

endpackage

// File: rtl/shift_receiver_counter.sv
// Frame bit counter: load-to-1, increment, clear, terminal at WIDTH.
// Shared by both parity and non-parity builds of shift_receiver.
module rx_bit_counter
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load_one,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clock) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load_one) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(WIDTH));

endmodule

// File: rtl/shift_receiver.sv
// Serial-in/parallel-out receiver with valid/ready output holding register.
// Define SHIFT_RX_PARITY_EN to expect an even-parity bit after each frame.
module shift_receiver
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err,
    input  logic             clr_err
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] load_word;
    logic [CNT_W-1:0] count;
    logic             terminal;
    logic             unused_terminal;
    logic             last_bit;
    logic             shift_en;
    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             load;
    logic             ferr_set;

    rx_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock    (clock),
        .rst      (rst),
        .load_one (cnt_load),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .count    (count),
        .terminal (terminal)
    );

    assign unused_terminal = terminal;
    assign last_bit        = (count == CNT_W'(WIDTH - 1));
    assign sr_next         = {sin, sr[WIDTH-1:1]};
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (sin_valid && frame_start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sin_valid && !frame_start && last_bit) begin
`ifdef SHIFT_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef SHIFT_RX_PARITY_EN
            ST_PARITY: begin
                if (sin_valid) begin
                    state_next = frame_start ? ST_SHIFT : ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        load     = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sin_valid && frame_start) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sin_valid) begin
                    shift_en = 1'b1;
                    if (frame_start) begin
                        ferr_set = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
`ifdef SHIFT_RX_PARITY_EN
                        cnt_inc = 1'b1;
`else
                        if (last_bit) begin
                            load    = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef SHIFT_RX_PARITY_EN
            ST_PARITY: begin
                if (sin_valid) begin
                    if (frame_start) begin
                        shift_en = 1'b1;
                        ferr_set = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        load    = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Parity bit is not shifted in, so the word is already complete in sr.
`ifdef SHIFT_RX_PARITY_EN
    assign load_word = sr;
`else
    assign load_word = sr_next;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            sr        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (shift_en) begin
                sr <= sr_next;
            end
            if (load) begin
                out       <= load_word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= (^sr) ^ sin;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_receiver.sv
// Self-checking bench for shift_receiver: directed frames plus random traffic
// compared every cycle against a bit-queue model of the receiver.
module tb_shift_receiver;

    localparam int W = 8;
`ifdef SHIFT_RX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;
    logic         parity_err;

    shift_receiver #(.WIDTH(W)) dut (
        .clock       (clock),
        .rst         (rst),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .frame_start (frame_start),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .clr_err     (clr_err)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // Model: a frame is the list of bits since the last frame_start.
    bit           m_valid = 0;
    bit           m_ovr = 0;
    bit           m_ferr = 0;
    bit           m_par = 0;
    bit           m_busy = 0;
    logic [W-1:0] m_out = '0;
    bit           q[$];
    bit           started = 0;

    always @(posedge clock) begin : model
        bit           ld;
        bit           fset;
        logic [W-1:0] w;
        int           ones;
        started = 1;
        ld = 0;
        fset = 0;
        w = '0;
        if (rst) begin
            m_valid = 0;
            m_ovr = 0;
            m_ferr = 0;
            m_par = 0;
            m_busy = 0;
            m_out = '0;
            q.delete();
        end else begin
            if (sin_valid) begin
                if (frame_start) begin
                    if (m_busy) fset = 1;
                    q.delete();
                    q.push_back(sin);
                    m_busy = 1;
                end else if (m_busy) begin
                    q.push_back(sin);
                    if (q.size() == NB) begin
                        ld = 1;
                        for (int i = 0; i < W; i++) w[i] = q[i];
                        m_busy = 0;
                    end
                end
            end
            if (clr_err) begin
                m_ovr = 0;
                m_ferr = 0;
            end
            if (fset) m_ferr = 1;
            if (ld) begin
                if (m_valid && !out_ready) m_ovr = 1;
                m_out = w;
                m_valid = 1;
`ifdef SHIFT_RX_PARITY_EN
                ones = $countones(w) + int'(q[W]);
                m_par = (ones % 2) != 0;
`else
                ones = 0;
`endif
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("out", 32'(out), 32'(m_out));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("parity_err", 32'(parity_err), 32'(m_par));
        end
    end

    task automatic send_bit(input bit b, input bit fs, input int gap);
        sin = b;
        sin_valid = 1'b1;
        frame_start = fs;
        @(negedge clock);
        sin = 1'b0;
        sin_valid = 1'b0;
        frame_start = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap,
                             input bit bad_par);
        for (int i = 0; i < W; i++)
            send_bit(w[i], i == 0, (i == NB - 1) ? 0 : gap);
`ifdef SHIFT_RX_PARITY_EN
        send_bit((^w) ^ bad_par, 1'b0, 0);
`else
        if (bad_par) $display("note: parity disabled");
`endif
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flags", 32'({overrun, frame_err, parity_err}), 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);

        send_word(8'hA5, 0, 0);
        chk("t1_out", 32'(out), 32'hA5);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_busy", 32'(busy), 32'h0);
        @(negedge clock);
        chk("t1_drain", 32'(out_valid), 32'h0);

        send_word(8'h3C, 3, 0);
        chk("t2_out", 32'(out), 32'h3C);
        repeat (2) @(negedge clock);

        out_ready = 1'b0;
        send_word(8'h11, 0, 0);
        send_word(8'h22, 0, 0);
        chk("t3_out", 32'(out), 32'h22);
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_ovr", 32'(overrun), 32'h1);
        pulse_clr();
        chk("t3_clr", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 0);
        send_word(8'h5A, 0, 0);
        chk("t4_ferr", 32'(frame_err), 32'h1);
        chk("t4_out", 32'(out), 32'h5A);
        pulse_clr();
        chk("t4_clr", 32'(frame_err), 32'h0);

        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 0);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        send_word(8'h0F, 0, 0);
        chk("t5_out", 32'(out), 32'h0F);
        chk("t5_flags", 32'({overrun, frame_err}), 32'h0);

`ifdef SHIFT_RX_PARITY_EN
        send_word(8'h07, 0, 0);
        chk("t6_good", 32'(parity_err), 32'h0);
        send_word(8'h07, 0, 1);
        chk("t6_bad", 32'(parity_err), 32'h1);
        chk("t6_out", 32'(out), 32'h07);
`endif

        repeat (3000) begin
            rst = ($urandom % 400) == 0;
            sin_valid = ($urandom % 3) != 0;
            sin = 1'($urandom);
            frame_start = ($urandom % 10) == 0;
            out_ready = 1'($urandom);
            clr_err = ($urandom % 16) == 0;
            @(negedge clock);
        end
        rst = 1'b0;
        sin_valid = 1'b0;
        frame_start = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
